// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle timing interface: measurement states and
// default geometry, used by both the decoder and the paddle emulation logic.
package paddle_pkg;

    localparam int DEF_CNT_W     = 8;
    localparam int DEF_MAX_LINES = 255;
    localparam int DEF_SETTLE    = 4;
    localparam int DEF_FILT      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } paddle_state_e;

endpackage

// File: rtl/pin_qualifier.sv
// Synchronizes the asynchronous paddle comparator line and qualifies it high
// only after FILT consecutive high samples; hold_clr forces the filter to zero.
module pin_qualifier #(
    parameter int FILT = 3
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pin_in,
    input  logic hold_clr,
    output logic pin_q
);

    localparam int FW = $clog2(FILT + 1);
    localparam logic [FW-1:0] FILT_V = FW'(FILT);

    logic [1:0]    sync_q;
    logic [1:0]    sync_d;
    logic [FW-1:0] filt_q;
    logic [FW-1:0] filt_d;

    always_comb begin
        sync_d = {sync_q[0], pin_in};
        filt_d = filt_q;
        // Saturating run-length of high samples; any low sample restarts it.
        if (hold_clr || !sync_q[1]) begin
            filt_d = '0;
        end else if (filt_q != FILT_V) begin
            filt_d = filt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            filt_q <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
        end
    end

    assign pin_q = (filt_q == FILT_V);

endmodule

// File: rtl/paddle_pos_decoder.sv
// Measures how many HSYNC lines the paddle line stays low after each VSYNC
// rise and reports that count as the paddle position, with timeout flagging.
module paddle_pos_decoder
    import paddle_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_LINES = DEF_MAX_LINES,
    parameter int SETTLE    = DEF_SETTLE,
    parameter int FILT      = DEF_FILT
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             hs,
    input  logic             vs,
    input  logic             pin_in,
    output logic [CNT_W-1:0] pos,
    output logic             pos_valid,
    output logic             timeout,
    output logic             busy
);

    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0]    SETTLE_V = SW'(SETTLE);
    localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(MAX_LINES);
    localparam logic [CNT_W-1:0] MAX_M1   = CNT_W'(MAX_LINES - 1);

    paddle_state_e    state_q, state_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             pos_valid_q, pos_valid_d;
    logic             timeout_q, timeout_d;
    logic             hs_prev_q, vs_prev_q;

    logic hs_rise;
    logic vs_rise;
    logic pin_q;
    logic pin_ok;
    logic hold_clr;

    assign hs_rise  = hs & ~hs_prev_q;
    assign vs_rise  = vs & ~vs_prev_q;
    assign pin_ok   = (settle_cnt_q == '0) && pin_q;
    // The filter restarts on every re-arm and stays cleared while settling,
    // so a high level left over from the previous frame cannot qualify.
    assign hold_clr = vs_rise || ((state_q == COUNT) && (settle_cnt_q != '0));

    pin_qualifier #(
        .FILT (FILT)
    ) u_pin_qualifier (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .pin_in   (pin_in),
        .hold_clr (hold_clr),
        .pin_q    (pin_q)
    );

    always_comb begin
        state_d      = state_q;
        line_cnt_d   = line_cnt_q;
        settle_cnt_d = settle_cnt_q;
        pos_d        = pos_q;
        pos_valid_d  = 1'b0;
        timeout_d    = timeout_q;

        case (state_q)
            IDLE, DONE: begin
                if (vs_rise) begin
                    line_cnt_d   = '0;
                    settle_cnt_d = SETTLE_V;
                    state_d      = COUNT;
                end
            end
            COUNT: begin
                if (vs_rise) begin
                    // Short frame: report what was counted and start over.
                    pos_d        = line_cnt_q;
                    timeout_d    = 1'b1;
                    pos_valid_d  = 1'b1;
                    line_cnt_d   = '0;
                    settle_cnt_d = SETTLE_V;
                end else begin
                    if (settle_cnt_q != '0) begin
                        settle_cnt_d = settle_cnt_q - 1'b1;
                    end
                    if (pin_ok) begin
                        pos_d       = line_cnt_q;
                        timeout_d   = 1'b0;
                        pos_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (hs_rise) begin
                        if (line_cnt_q == MAX_M1) begin
                            line_cnt_d  = MAX_V;
                            pos_d       = MAX_V;
                            timeout_d   = 1'b1;
                            pos_valid_d = 1'b1;
                            state_d     = DONE;
                        end else begin
                            line_cnt_d = line_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            line_cnt_q   <= '0;
            settle_cnt_q <= '0;
            pos_q        <= '0;
            pos_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_cnt_q   <= line_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            pos_q        <= pos_d;
            pos_valid_q  <= pos_valid_d;
            timeout_q    <= timeout_d;
            hs_prev_q    <= hs;
            vs_prev_q    <= vs;
        end
    end

    assign pos       = pos_q;
    assign pos_valid = pos_valid_q;
    assign timeout   = timeout_q;
    assign busy      = (state_q == COUNT);

endmodule

// File: tb/tb_paddle_pos_decoder.sv
// Segment-based bench: builds vs/hs/pin waveforms, drives them, and compares the
// observed strobes against an event-level model of the measurement rules.
module tb_paddle_pos_decoder;

    localparam int CNT_W     = 8;
    localparam int MAX_LINES = 255;
    localparam int SETTLE    = 4;
    localparam int FILT      = 3;
    localparam int MAXC      = 20000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             hs = 1'b0;
    logic             vs = 1'b0;
    logic             pin_in = 1'b0;
    logic [CNT_W-1:0] pos;
    logic             pos_valid;
    logic             timeout;
    logic             busy;

    paddle_pos_decoder #(
        .CNT_W     (CNT_W),
        .MAX_LINES (MAX_LINES),
        .SETTLE    (SETTLE),
        .FILT      (FILT)
    ) dut (
        .clk_sys   (clk),
        .reset     (reset),
        .hs        (hs),
        .vs        (vs),
        .pin_in    (pin_in),
        .pos       (pos),
        .pos_valid (pos_valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    bit vs_a  [MAXC];
    bit hs_a  [MAXC];
    bit pin_a [MAXC];
    int len;
    int cur;
    bit mon_en = 1'b0;

    int obs_cyc[$];
    int obs_pos[$];
    int obs_to[$];
    int exp_cyc[$];
    int exp_pos[$];
    int exp_to[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && pos_valid) begin
            obs_cyc.push_back(cur);
            obs_pos.push_back(int'(pos));
            obs_to.push_back(int'(timeout));
        end
    end

    // One frame: hs high for 2 cycles at each line start, vs high for 3 cycles
    // in the middle of line 0 so it never coincides with an hs edge.
    task automatic add_frame(input int lines, input int per);
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < per; c++) begin
                int idx;
                idx = len + l * per + c;
                hs_a[idx]  = (c < 2);
                vs_a[idx]  = (l == 0) && (c >= per / 2) && (c < per / 2 + 3);
                pin_a[idx] = 1'b0;
            end
        end
        len += lines * per;
    endtask

    task automatic set_pin(input int a, input int b);
        for (int k = a; k < b && k < len; k++) pin_a[k] = 1'b1;
    endtask

    // Paddle emulator: cap loads N at vs, decrements per hs, line high at zero.
    task automatic emu_fill(input int n);
        int cap;
        cap = 0;
        for (int k = 0; k < len; k++) begin
            if (vs_a[k] && (k == 0 || !vs_a[k-1])) cap = n;
            else if (hs_a[k] && (k == 0 || !hs_a[k-1]) && cap > 0) cap--;
            pin_a[k] = (cap == 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        hs = 1'b0;
        vs = 1'b0;
        pin_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pos", pos, 0);
        check_val("rst_valid", pos_valid, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drive_seg();
        obs_cyc.delete();
        obs_pos.delete();
        obs_to.delete();
        mon_en = 1'b1;
        for (int k = 0; k < len; k++) begin
            vs = vs_a[k];
            hs = hs_a[k];
            pin_in = pin_a[k];
            @(posedge clk);
            cur = k;
            #1;
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
    endtask

    // Per frame: the pin counts once it has been high for 2 sync + FILT samples
    // and the settle window plus filter depth has elapsed; the earliest of pin,
    // the MAX_LINES-th line, or the next vs decides the reported strobe.
    task automatic run_model();
        int vr[$];
        exp_cyc.delete();
        exp_pos.delete();
        exp_to.delete();
        for (int k = 0; k < len; k++)
            if (vs_a[k] && (k == 0 || !vs_a[k-1])) vr.push_back(k);
        for (int i = 0; i < vr.size(); i++) begin
            int v, v2, q, cnt, cnt_q, h_max;
            bit ok;
            v  = vr[i];
            v2 = (i + 1 < vr.size()) ? vr[i+1] : len;
            q  = -1;
            for (int k = v + SETTLE + FILT + 1; k < v2 && q < 0; k++) begin
                ok = 1'b1;
                for (int j = k - FILT - 2; j <= k - 3; j++)
                    if (j < 0 || !pin_a[j]) ok = 1'b0;
                if (ok) q = k;
            end
            cnt = 0;
            cnt_q = 0;
            h_max = -1;
            for (int k = v + 1; k < v2; k++) begin
                if (hs_a[k] && !hs_a[k-1]) begin
                    if (q < 0 || k < q) cnt_q++;
                    cnt++;
                    if (cnt == MAX_LINES && h_max < 0) h_max = k;
                end
            end
            if (q >= 0 && (h_max < 0 || q <= h_max)) begin
                exp_cyc.push_back(q);
                exp_pos.push_back(cnt_q);
                exp_to.push_back(0);
            end else if (h_max >= 0) begin
                exp_cyc.push_back(h_max);
                exp_pos.push_back(MAX_LINES);
                exp_to.push_back(1);
            end else if (i + 1 < vr.size()) begin
                exp_cyc.push_back(v2);
                exp_pos.push_back(cnt);
                exp_to.push_back(1);
            end
        end
    endtask

    task automatic compare_seg(input string name);
        run_model();
        check_val({name, "_count"}, obs_cyc.size(), exp_cyc.size());
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            $display("%s strobe %0d: cyc %0d pos %0d timeout %0d (model cyc %0d pos %0d timeout %0d)",
                     name, i, obs_cyc[i], obs_pos[i], obs_to[i], exp_cyc[i], exp_pos[i], exp_to[i]);
            check_val({name, "_cyc"}, obs_cyc[i], exp_cyc[i]);
            check_val({name, "_pos"}, obs_pos[i], exp_pos[i]);
            check_val({name, "_timeout"}, obs_to[i], exp_to[i]);
        end
    endtask

    task automatic random_seg(input string name);
        int bases[$];
        int lns[$];
        int pers[$];
        int lines, per, base, st, gs;
        len = 0;
        for (int f = 0; f < 5; f++) begin
            lines = $urandom_range(10, 280);
            per = $urandom_range(8, 12);
            bases.push_back(len);
            lns.push_back(lines);
            pers.push_back(per);
            add_frame(lines, per);
        end
        add_frame(3, 8);
        for (int f = 0; f < 5; f++) begin
            base = bases[f];
            st = base + $urandom_range(0, lns[f] + 10) * pers[f] + $urandom_range(0, pers[f] - 1);
            set_pin(st, base + lns[f] * pers[f] + $urandom_range(0, 12));
            gs = base + $urandom_range(0, lns[f] * pers[f] - 1);
            set_pin(gs, gs + $urandom_range(1, FILT));
        end
        do_reset();
        drive_seg();
        compare_seg(name);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Loopback, cap=100, three full frames.
        len = 0;
        repeat (3) add_frame(262, 16);
        add_frame(5, 16);
        emu_fill(100);
        do_reset();
        drive_seg();
        compare_seg("loop100");

        // cap=0: pin already high across the vs rise.
        len = 0;
        repeat (4) add_frame(20, 16);
        emu_fill(0);
        do_reset();
        drive_seg();
        compare_seg("cap0");

        // Pin low: full-frame timeout, then two short frames.
        len = 0;
        add_frame(262, 8);
        add_frame(40, 8);
        add_frame(10, 8);
        add_frame(3, 8);
        do_reset();
        drive_seg();
        compare_seg("lowpin");

        // Glitch of FILT-1 cycles at line 20, steady high from line 60.
        len = 0;
        add_frame(262, 8);
        add_frame(262, 8);
        add_frame(5, 8);
        set_pin(20 * 8 + 3, 20 * 8 + 3 + FILT - 1);
        set_pin(60 * 8 + 3, 262 * 8 + 6);
        do_reset();
        drive_seg();
        compare_seg("glitch");

        // Reset at line 30 of an active measurement.
        len = 0;
        add_frame(262, 8);
        add_frame(31, 8);
        emu_fill(77);
        do_reset();
        drive_seg();
        compare_seg("prerst");
        check_val("busy_mid", busy, 1);
        check_val("pos_mid", pos, 77);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_pos", pos, 0);
        check_val("async_valid", pos_valid, 0);
        check_val("async_timeout", timeout, 0);
        check_val("async_busy", busy, 0);
        repeat (4) begin
            @(negedge clk);
            check_val("rst_hold_valid", pos_valid, 0);
        end
        len = 0;
        add_frame(262, 8);
        add_frame(262, 8);
        add_frame(5, 8);
        emu_fill(50);
        do_reset();
        drive_seg();
        compare_seg("postrst");

        random_seg("rand_a");
        random_seg("rand_b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
